// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and constants for the two-master RAM bus arbiter.
package ram_bus_arbiter_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_ACCESS_CYCLES = 2;
  localparam int DEF_MAX_LOCK      = 8;

  // Master indices as carried by owner / last_winner
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Bundle of the two master request ports, the shared RAM bus and the grant.
// slave: the arbiter's view. master: the view of the masters plus the RAM.
interface ram_bus_arbiter_if
  import ram_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_adr;
  logic                  m0_we;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m0_ack;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_adr;
  logic                  m1_we;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_ack;
  logic                  m1_lock;

  logic [ADDR_WIDTH-1:0] bus_adr;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;

  logic [1:0]            grant;

  modport slave (
    input  m0_req, m0_adr, m0_we, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_adr, m1_we, m1_wdata, m1_lock,
    output m1_rdata, m1_ack,
    output bus_adr, bus_we, bus_wdata,
    input  bus_rdata,
    output grant
  );

  modport master (
    output m0_req, m0_adr, m0_we, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_adr, m1_we, m1_wdata, m1_lock,
    input  m1_rdata, m1_ack,
    input  bus_adr, bus_we, bus_wdata,
    output bus_rdata,
    input  grant
  );

endinterface

// File: rtl/ram_bus_arbiter_rr_priority_select.sv
// Combinational two-way winner pick: round-robin on a tie, with master 1
// allowed to keep the bus while its lock qualifier is true.
module rr_priority_select
  import ram_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  input  logic lock_ok,
  output logic valid,
  output logic winner
);

  // Pick the winner among the current requesters
  always_comb begin
    valid  = req0 | req1;
    winner = M0;
    if (req0 && req1) begin
      if (last_winner == M1 && lock_ok) begin
        winner = M1;
      end else begin
        winner = ~last_winner;
      end
    end else if (req1) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for the single-port data RAM bus. Each access holds the
// bus for ACCESS_CYCLES cycles, then returns a one-cycle ack and read data.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int MAX_LOCK      = DEF_MAX_LOCK
) (
  input logic              clk,
  input logic              rst,
  ram_bus_arbiter_if.slave arb
);

  localparam int CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic                  owner;
  logic                  last_winner;
  logic [LOCK_W-1:0]     lock_cnt;
  logic                  lock_ok;
  logic                  pick_valid;
  logic                  pick_winner;
  logic [ADDR_WIDTH-1:0] sel_adr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign lock_ok = arb.m1_lock && (lock_cnt < LOCK_MAX);

  rr_priority_select u_select (
    .req0        (arb.m0_req),
    .req1        (arb.m1_req),
    .last_winner (last_winner),
    .lock_ok     (lock_ok),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  // Route the winning master's request fields toward the bus registers
  always_comb begin
    sel_adr   = arb.m0_adr;
    sel_we    = arb.m0_we;
    sel_wdata = arb.m0_wdata;
    if (pick_winner == M1) begin
      sel_adr   = arb.m1_adr;
      sel_we    = arb.m1_we;
      sel_wdata = arb.m1_wdata;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (pick_valid) next_state = ACCESS;
      ACCESS:  if (cnt == '0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bus drive, access counter, read-data capture and ack pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      owner         <= M0;
      cnt           <= '0;
      arb.grant     <= '0;
      arb.bus_adr   <= '0;
      arb.bus_we    <= 1'b0;
      arb.bus_wdata <= '0;
      arb.m0_ack    <= 1'b0;
      arb.m1_ack    <= 1'b0;
      arb.m0_rdata  <= '0;
      arb.m1_rdata  <= '0;
    end else begin
      arb.m0_ack <= 1'b0;
      arb.m1_ack <= 1'b0;
      arb.bus_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner         <= pick_winner;
            arb.grant     <= (pick_winner == M1) ? 2'b10 : 2'b01;
            arb.bus_adr   <= sel_adr;
            arb.bus_we    <= sel_we;
            arb.bus_wdata <= sel_wdata;
            cnt           <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (owner == M1) begin
              arb.m1_rdata <= arb.bus_rdata;
              arb.m1_ack   <= 1'b1;
            end else begin
              arb.m0_rdata <= arb.bus_rdata;
              arb.m0_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK: begin
          arb.grant <= '0;
        end
        default: begin
          arb.grant <= '0;
        end
      endcase
    end
  end

  // Round-robin history and master-1 lock run length
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= M1;
      lock_cnt    <= '0;
    end else begin
      if (state == ACK) begin
        last_winner <= owner;
      end
      if (!arb.m1_lock) begin
        lock_cnt <= '0;
      end else if (state == ACK) begin
        if (owner == M1) begin
          lock_cnt <= (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);
        end else begin
          lock_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: drivers queue expected read data per
// master, a negedge monitor checks grant/bus/ack timing and pops on every ack.
module tb_ram_bus_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int AC  = 2;
  localparam int MAXL = 8;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ram_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

  ram_bus_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .ACCESS_CYCLES (AC),
    .MAX_LOCK      (MAXL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (ifc)
  );

  always #5 clk = ~clk;

  // ---------------- RAM device (synchronous read) ----------------
  logic [DW-1:0] mem [256];
  bit            written [256];

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {24'hC0FFEE, a};
  endfunction

  always @(posedge clk) begin
    if (ifc.bus_we) begin
      mem[ifc.bus_adr[7:0]]     <= ifc.bus_wdata;
      written[ifc.bus_adr[7:0]] <= 1'b1;
    end
    ifc.bus_rdata <= written[ifc.bus_adr[7:0]] ? mem[ifc.bus_adr[7:0]]
                                               : init_word(ifc.bus_adr[7:0]);
  end

  // ---------------- reference memory and scoreboard ----------------
  logic [DW-1:0] sh_mem [256];
  bit            sh_written [256];
  exp_t          q0[$];
  exp_t          q1[$];

  function automatic logic [DW-1:0] sh_read(input logic [7:0] a);
    return sh_written[a] ? sh_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- monitor with transaction-level arbitration model ----------------
  // s_* hold the inputs as the DUT sampled them at the preceding posedge.
  logic          s_rst = 1'b1;
  logic          s_req0 = 1'b0, s_req1 = 1'b0, s_lock = 1'b0;
  logic          s_we0 = 1'b0, s_we1 = 1'b0;
  logic [AW-1:0] s_adr0 = '0, s_adr1 = '0;
  logic [DW-1:0] s_wd0 = '0, s_wd1 = '0;
  bit            busy = 1'b0;
  int            k = 0;
  bit            win = 1'b0;
  bit            m_last = 1'b1;
  int            m_cnt = 0;
  logic [1:0]    exp_grant = 2'b00;
  logic [AW-1:0] exp_adr = '0;
  logic [DW-1:0] exp_wd = '0;
  exp_t          e;

  always @(negedge clk) begin
    if (s_rst) begin
      busy   = 1'b0;
      m_last = 1'b1;
      m_cnt  = 0;
      chk("reset grant", {62'd0, ifc.grant}, 64'd0);
      chk("reset bus_we", {63'd0, ifc.bus_we}, 64'd0);
      chk("reset bus_adr", {32'd0, ifc.bus_adr}, 64'd0);
      chk("reset bus_wdata", {32'd0, ifc.bus_wdata}, 64'd0);
      chk("reset acks", {62'd0, ifc.m1_ack, ifc.m0_ack}, 64'd0);
      chk("reset rdata", {ifc.m1_rdata, ifc.m0_rdata}, 64'd0);
    end else if (!busy) begin
      if (s_req0 || s_req1) begin
        if (s_req0 && s_req1) begin
          win = (m_last && s_lock && m_cnt < MAXL) ? 1'b1 : !m_last;
        end else begin
          win = s_req1;
        end
        busy      = 1'b1;
        k         = 0;
        exp_grant = win ? 2'b10 : 2'b01;
        exp_adr   = win ? s_adr1 : s_adr0;
        exp_wd    = win ? s_wd1 : s_wd0;
        chk("start grant", {62'd0, ifc.grant}, {62'd0, exp_grant});
        chk("start bus_adr", {32'd0, ifc.bus_adr}, {32'd0, exp_adr});
        chk("start bus_we", {63'd0, ifc.bus_we}, {63'd0, win ? s_we1 : s_we0});
        chk("start bus_wdata", {32'd0, ifc.bus_wdata}, {32'd0, exp_wd});
      end else begin
        chk("idle grant", {62'd0, ifc.grant}, 64'd0);
        chk("idle bus_we", {63'd0, ifc.bus_we}, 64'd0);
      end
      chk("no ack", {62'd0, ifc.m1_ack, ifc.m0_ack}, 64'd0);
      if (!s_lock) m_cnt = 0;
    end else begin
      k++;
      if (k < AC) begin
        chk("access grant", {62'd0, ifc.grant}, {62'd0, exp_grant});
        chk("access bus_we", {63'd0, ifc.bus_we}, 64'd0);
        chk("access bus_adr", {32'd0, ifc.bus_adr}, {32'd0, exp_adr});
        chk("access bus_wdata", {32'd0, ifc.bus_wdata}, {32'd0, exp_wd});
        chk("access acks", {62'd0, ifc.m1_ack, ifc.m0_ack}, 64'd0);
      end else if (k == AC) begin
        chk("ack grant", {62'd0, ifc.grant}, {62'd0, exp_grant});
        chk("ack pulse", {62'd0, ifc.m1_ack, ifc.m0_ack}, {62'd0, exp_grant});
        chk("ack bus_we", {63'd0, ifc.bus_we}, 64'd0);
        if ((win ? q1.size() : q0.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected ack m%0d at %0t: got ack expected none", win, $time);
        end else begin
          e = win ? q1.pop_front() : q0.pop_front();
          if (!e.we) begin
            chk(win ? "m1_rdata" : "m0_rdata", {32'd0, win ? ifc.m1_rdata : ifc.m0_rdata},
                {32'd0, e.data});
          end
        end
      end else begin
        m_cnt  = (win && s_lock) ? ((m_cnt < MAXL) ? m_cnt + 1 : MAXL) : 0;
        m_last = win;
        busy   = 1'b0;
        chk("post-ack grant", {62'd0, ifc.grant}, 64'd0);
        chk("post-ack acks", {62'd0, ifc.m1_ack, ifc.m0_ack}, 64'd0);
      end
      if (!s_lock) m_cnt = 0;
    end
    s_rst  = rst;
    s_req0 = ifc.m0_req;  s_req1 = ifc.m1_req;  s_lock = ifc.m1_lock;
    s_adr0 = ifc.m0_adr;  s_adr1 = ifc.m1_adr;
    s_we0  = ifc.m0_we;   s_we1  = ifc.m1_we;
    s_wd0  = ifc.m0_wdata; s_wd1 = ifc.m1_wdata;
  end

  // ---------------- stimulus ----------------
  // Tasks start and end just after a posedge.
  task automatic drop(input bit m);
    if (m) ifc.m1_req = 1'b0;
    else   ifc.m0_req = 1'b0;
  endtask

  task automatic do_access(input bit m, input logic [AW-1:0] adr, input bit we,
                           input logic [DW-1:0] wd);
    exp_t ex;
    bit   got;
    ex.we   = we;
    ex.data = we ? '0 : sh_read(adr[7:0]);
    if (we) begin
      sh_mem[adr[7:0]]     = wd;
      sh_written[adr[7:0]] = 1'b1;
    end
    if (m) begin
      ifc.m1_req = 1'b1; ifc.m1_adr = adr; ifc.m1_we = we; ifc.m1_wdata = wd;
      q1.push_back(ex);
    end else begin
      ifc.m0_req = 1'b1; ifc.m0_adr = adr; ifc.m0_we = we; ifc.m0_wdata = wd;
      q0.push_back(ex);
    end
    got = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m ? ifc.m1_ack : ifc.m0_ack) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack timeout m%0d adr %0h: got no ack expected ack within 300 cycles", m, adr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_master(input bit m, input int unsigned n, input int unsigned gap_max);
    logic [AW-1:0] adr;
    int unsigned   gap;
    for (int unsigned i = 0; i < n; i++) begin
      adr = m ? AW'(128 + $urandom_range(0, 127)) : AW'($urandom_range(0, 127));
      do_access(m, adr, 1'($urandom_range(0, 1)), $urandom);
      gap = $urandom_range(0, gap_max);
      if (i == n - 1) begin
        drop(m);
      end else if (gap > 0) begin
        drop(m);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drop(0);
    drop(1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    bit seen = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.grant != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL grant timeout: got grant 00 expected nonzero within 20 cycles");
    end
  endtask

  initial begin
    ifc.m0_req = 1'b0; ifc.m0_adr = '0; ifc.m0_we = 1'b0; ifc.m0_wdata = '0;
    ifc.m1_req = 1'b0; ifc.m1_adr = '0; ifc.m1_we = 1'b0; ifc.m1_wdata = '0;
    ifc.m1_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read, then write by m1 read back by m0
    do_access(0, 32'h10, 1'b0, '0);
    drop(0);
    do_access(1, 32'h20, 1'b1, 32'h12345678);
    drop(1);
    do_access(0, 32'h20, 1'b0, '0);
    drop(0);

    // Continuous requests from both masters after reset, no lock
    do_reset();
    fork
      run_master(0, 4, 0);
      run_master(1, 4, 0);
    join

    // Master 1 locked against a waiting master 0
    ifc.m1_lock = 1'b1;
    fork
      run_master(0, 2, 0);
      run_master(1, 18, 0);
    join
    ifc.m1_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the second cycle of an m0 write; the RAM already took the write
    ifc.m0_req = 1'b1; ifc.m0_adr = 32'h30; ifc.m0_we = 1'b1; ifc.m0_wdata = 32'hCAFE0030;
    wait_grant();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifc.m0_req = 1'b0;
    sh_mem[8'h30]     = 32'hCAFE0030;
    sh_written[8'h30] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_access(0, 32'h30, 1'b0, '0);
    drop(0);

    // m0 drops req during the second access cycle
    ifc.m0_req = 1'b1; ifc.m0_adr = 32'h10; ifc.m0_we = 1'b0;
    q0.push_back('{we: 1'b0, data: sh_read(8'h10)});
    wait_grant();
    @(posedge clk);
    #1;
    ifc.m0_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("dropped req queue drained", 64'(q0.size()), 64'd0);

    // Randomized traffic, unlocked then locked
    for (int unsigned seg = 0; seg < 2; seg++) begin
      ifc.m1_lock = 1'(seg);
      fork
        run_master(0, 25, 3);
        run_master(1, 25, 3);
      join
      ifc.m1_lock = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end

    chk("m0 queue drained", 64'(q0.size()), 64'd0);
    chk("m1 queue drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
